// File: rtl/mult_div_pkg.sv
// mult_div_pkg: MDOp encodings and latencies shared by the multiply/divide unit, decoder and hazard unit.
package mult_div_pkg;
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    function automatic logic is_long_op(input logic [3:0] op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction

    function automatic logic is_md_op(input logic [3:0] op);
        return op >= MD_MULT && op <= MD_MTLO;
    endfunction
endpackage

// File: rtl/mult_div.sv
// mult_div: HI/LO multiply/divide unit with fixed 5-cycle multiply and 10-cycle divide latency.
module mult_div
    import mult_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Start,
    input  logic        Flush,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    logic [31:0] a_q, b_q;
    logic [3:0]  op_q, cnt;
    logic        accept, is_mul, sign_a, sign_b, wr_en;
    logic [31:0] mag_a, mag_b, div_b, quo, rem;
    logic [63:0] prod, res;

    assign accept = Start & ~Flush & ~Busy & is_md_op(MDOp);
    assign is_mul = op_q == MD_MULT || op_q == MD_MULTU;

    // Low 64 bits of a 64x64 product of sign/zero-extended operands give the exact result.
    assign prod = op_q == MD_MULT ? {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q}
                                  : {32'd0, a_q} * {32'd0, b_q};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    assign sign_a = op_q == MD_DIV && a_q[31];
    assign sign_b = op_q == MD_DIV && b_q[31];
    assign mag_a  = sign_a ? -a_q : a_q;
    assign mag_b  = sign_b ? -b_q : b_q;
    assign div_b  = mag_b == 32'd0 ? 32'd1 : mag_b;
    assign quo    = mag_a / div_b;
    assign rem    = mag_a % div_b;

    assign res   = is_mul ? prod : {sign_a ? -rem : rem, (sign_a ^ sign_b) ? -quo : quo};
    assign wr_en = is_mul || b_q != 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            op_q <= MD_NONE;
            cnt  <= 4'd0;
            Busy <= 1'b0;
            HI   <= 32'd0;
            LO   <= 32'd0;
        end else if (Busy) begin
            if (cnt == 4'd1) begin
                Busy <= 1'b0;
                cnt  <= 4'd0;
                if (wr_en) begin
                    HI <= res[63:32];
                    LO <= res[31:0];
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (accept) begin
            if (MDOp == MD_MTHI) begin
                HI <= A;
            end else if (MDOp == MD_MTLO) begin
                LO <= A;
            end else begin
                a_q  <= A;
                b_q  <= B;
                op_q <= MDOp;
                Busy <= 1'b1;
                cnt  <= (MDOp == MD_MULT || MDOp == MD_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            end
        end
    end
endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: directed vector table plus hand-written reset/flush sequences for mult_div.
module tb_mult_div;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic [3:0]  MDOp = 4'd0;
    logic        Start = 1'b0, Flush = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO;
    int total = 0, bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cycles;
    } vec_t;

    vec_t vecs[12];

    mult_div dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDOp(MDOp),
        .Start(Start), .Flush(Flush), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op at the next edge, then keep toggling garbage inputs while Busy.
    task automatic run(input vec_t v, input int idx);
        int n;
        @(negedge clk);
        A = v.a; B = v.b; MDOp = v.op; Start = 1'b1; Flush = 1'b0;
        @(posedge clk); #1;
        Start = 1'b0;
        n = 0;
        while (Busy && n < 20) begin
            A = $urandom; B = $urandom; MDOp = 4'($urandom_range(1, 6));
            Start = 1'b1; Flush = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            Start = 1'b0; Flush = 1'b0;
            n++;
        end
        chk($sformatf("v%0d cycles", idx), 32'(n), 32'(v.cycles));
        chk($sformatf("v%0d HI", idx), HI, v.hi);
        chk($sformatf("v%0d LO", idx), LO, v.lo);
    endtask

    task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic fl);
        @(negedge clk);
        A = a; B = 32'd3; MDOp = op; Start = 1'b1; Flush = fl;
        @(posedge clk); #1;
        Start = 1'b0; Flush = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{4'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[5]  = '{4'd4, 32'hFFFFFFFF, 32'd10,       32'h00000005, 32'h19999999, 10};
        vecs[6]  = '{4'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[7]  = '{4'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[8]  = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[9]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[10] = '{4'd5, 32'hAAAA5555, 32'd0,        32'hAAAA5555, 32'hFFFFFFFD, 0};
        vecs[11] = '{4'd6, 32'h0F0F0F0F, 32'd0,        32'hAAAA5555, 32'h0F0F0F0F, 0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        chk("reset Busy", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        pulse(4'd6, 32'hCAFEF00D, 1'b0);
        chk("first accept LO", LO, 32'hCAFEF00D);

        pulse(4'd5, 32'h12345678, 1'b1);
        chk("mthi flushed HI", HI, 32'd0);
        chk("mthi flushed Busy", 32'(Busy), 32'd0);
        pulse(4'd5, 32'h12345678, 1'b0);
        chk("mthi HI", HI, 32'h12345678);
        chk("mthi Busy", 32'(Busy), 32'd0);
        chk("mthi LO kept", LO, 32'hCAFEF00D);

        pulse(4'd1, 32'd9, 1'b1);
        chk("mult flushed Busy", 32'(Busy), 32'd0);
        pulse(4'd0, 32'd9, 1'b0);
        chk("op0 Busy", 32'(Busy), 32'd0);
        pulse(4'd9, 32'd9, 1'b0);
        chk("op9 Busy", 32'(Busy), 32'd0);
        chk("ignored ops HI", HI, 32'h12345678);
        chk("ignored ops LO", LO, 32'hCAFEF00D);

        foreach (vecs[i]) run(vecs[i], i);

        pulse(4'd3, 32'd100, 1'b0);
        chk("div started Busy", 32'(Busy), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        chk("abort Busy", 32'(Busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("post abort HI", HI, 32'd0);
        chk("post abort LO", LO, 32'd0);
        chk("post abort Busy", 32'(Busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
